// File: rtl/writeback_if.sv
// writeback_if: bundles the writeback unit's pipeline input, mul/div
// handshake and register-file write port.
//   pipe_valid/pipe_rd/pipe_data : single-cycle pipeline result (no stall)
//   md_valid/md_ready/md_rd/md_data : mul/div result, valid/ready handshake
//   we/rd_addr/rd_data           : registered register-file write port
//   md_pending                   : buffered md result count for hazard logic
// modport slave  : writeback unit side
// modport master : producer / register-file side
interface writeback_if #(
  parameter int XLEN     = 32,
  parameter int MD_DEPTH = 2
);
  logic                        pipe_valid;
  logic [4:0]                  pipe_rd;
  logic [XLEN-1:0]             pipe_data;
  logic                        md_valid;
  logic                        md_ready;
  logic [4:0]                  md_rd;
  logic [XLEN-1:0]             md_data;
  logic                        we;
  logic [4:0]                  rd_addr;
  logic [XLEN-1:0]             rd_data;
  logic [$clog2(MD_DEPTH):0]   md_pending;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    output md_ready, we, rd_addr, rd_data, md_pending
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    input  md_ready, we, rd_addr, rd_data, md_pending
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates the single register-file write slot between the
// never-stalling pipeline result and a small FIFO of mul/div results.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   wb    : writeback_if.slave (pipeline in, md handshake, rf write, md_pending)
// Parameters: XLEN data width, MD_DEPTH md buffer depth (power of 2, >= 2).
// Optional feature: define WB_BYPASS_EN to let an md result that arrives with
// an empty FIFO and an idle pipeline be written in the same edge.
module writeback_unit #(
  parameter int XLEN     = 32,
  parameter int MD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  writeback_if.slave  wb
);
  localparam int PW = $clog2(MD_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      fifo_rd   [MD_DEPTH];
  logic [XLEN-1:0] fifo_data [MD_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            md_ready_q;
  logic            we_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] rd_data_q;

  logic pipe_req, md_keep, fifo_empty, bypass, push, pop;

  always_comb begin
    pipe_req   = wb.pipe_valid && (wb.pipe_rd != 5'd0);
    // x0 md results complete the handshake but are dropped here
    md_keep    = wb.md_valid && md_ready_q && (wb.md_rd != 5'd0);
    fifo_empty = (count == '0);
`ifdef WB_BYPASS_EN
    bypass     = md_keep && fifo_empty && !pipe_req;
`else
    bypass     = 1'b0;
`endif
    push       = md_keep && !bypass;
    pop        = !pipe_req && !fifo_empty;
    count_nxt  = count + CW'(push) - CW'(pop);
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= wb.md_rd;
      fifo_data[wr_ptr] <= wb.md_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      md_ready_q <= 1'b1;
      we_q       <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      // Registered from next occupancy so a same-edge pop cannot reopen
      // md_ready combinationally.
      md_ready_q <= (count_nxt != CW'(MD_DEPTH));
      if (pipe_req) begin
        we_q      <= 1'b1;
        rd_addr_q <= wb.pipe_rd;
        rd_data_q <= wb.pipe_data;
      end else if (pop) begin
        we_q      <= 1'b1;
        rd_addr_q <= fifo_rd[rd_ptr];
        rd_data_q <= fifo_data[rd_ptr];
      end else if (bypass) begin
        we_q      <= 1'b1;
        rd_addr_q <= wb.md_rd;
        rd_data_q <= wb.md_data;
      end else begin
        we_q      <= 1'b0;
      end
    end
  end

  assign wb.md_ready   = md_ready_q;
  assign wb.we         = we_q;
  assign wb.rd_addr    = rd_addr_q;
  assign wb.rd_data    = rd_data_q;
  assign wb.md_pending = count;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table of directed single-cycle vectors, hand-written
// bypass and reset-mid-drain sequences, and a randomized run checked by a
// queue of accepted md results. Honors WB_BYPASS_EN like the design.
module tb_writeback_unit;
  localparam int XLEN = 32;
  localparam int MD_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  writeback_if #(.XLEN(XLEN), .MD_DEPTH(MD_DEPTH)) wb ();

  writeback_unit #(.XLEN(XLEN), .MD_DEPTH(MD_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  typedef struct {
    logic        pv;  logic [4:0] prd; logic [31:0] pd;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        we;  logic [4:0] ra;  logic [31:0] rdat;
    logic        rdy; logic [1:0] pend;
  } vec_t;

  typedef struct packed { logic [4:0] rd; logic [31:0] d; } wr_t;

  vec_t vt[14];
  wr_t  q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %0s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic pv, logic [4:0] prd, logic [31:0] pd,
                       logic mv, logic [4:0] mrd, logic [31:0] md);
    wb.pipe_valid = pv; wb.pipe_rd = prd; wb.pipe_data = pd;
    wb.md_valid = mv;   wb.md_rd = mrd;   wb.md_data = md;
  endtask

  initial begin
    wr_t e;
    int  old_sz;
    logic pr, pushed, exp_md_we;
    logic [4:0] pa;
    logic [31:0] pdat;

    drive(0, 0, 0, 0, 0, 0);
    // Table: pipe-only, x0 suppression, collision, back-pressure, drain.
    vt[0]  = '{1, 5'd1,  32'hA5A5A5A5, 0, 5'd0, 32'h0,        1, 5'd1,  32'hA5A5A5A5, 1, 2'd0};
    vt[1]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd1,  32'hA5A5A5A5, 1, 2'd0};
    vt[2]  = '{1, 5'd0,  32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd1,  32'hA5A5A5A5, 1, 2'd0};
    vt[3]  = '{1, 5'd2,  32'h11111111, 1, 5'd3, 32'h22222222, 1, 5'd2,  32'h11111111, 1, 2'd1};
    vt[4]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd3,  32'h22222222, 1, 2'd0};
    vt[5]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd3,  32'h22222222, 1, 2'd0};
    vt[6]  = '{1, 5'd8,  32'h80,       1, 5'd4, 32'h40,       1, 5'd8,  32'h80,       1, 2'd1};
    vt[7]  = '{1, 5'd9,  32'h90,       1, 5'd5, 32'h50,       1, 5'd9,  32'h90,       0, 2'd2};
    vt[8]  = '{1, 5'd10, 32'hA0,       1, 5'd6, 32'h60,       1, 5'd10, 32'hA0,       0, 2'd2};
    vt[9]  = '{1, 5'd11, 32'hB0,       1, 5'd6, 32'h60,       1, 5'd11, 32'hB0,       0, 2'd2};
    vt[10] = '{0, 5'd0,  32'h0,        1, 5'd6, 32'h60,       1, 5'd4,  32'h40,       1, 2'd1};
    vt[11] = '{0, 5'd0,  32'h0,        1, 5'd6, 32'h60,       1, 5'd5,  32'h50,       1, 2'd1};
    vt[12] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd6,  32'h60,       1, 2'd0};
    vt[13] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd6,  32'h60,       1, 2'd0};

    // Reset state, checked before any clock edge.
    #2 rst_n = 1'b0;
    #2;
    chk("rst_we", wb.we, 0);
    chk("rst_addr", wb.rd_addr, 0);
    chk("rst_data", wb.rd_data, 0);
    chk("rst_pend", wb.md_pending, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", wb.md_ready, 1);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].pv, vt[i].prd, vt[i].pd, vt[i].mv, vt[i].mrd, vt[i].md);
      tick();
      chk($sformatf("v%0d_we", i),   wb.we,         vt[i].we);
      chk($sformatf("v%0d_addr", i), wb.rd_addr,    vt[i].ra);
      chk($sformatf("v%0d_data", i), wb.rd_data,    vt[i].rdat);
      chk($sformatf("v%0d_rdy", i),  wb.md_ready,   vt[i].rdy);
      chk($sformatf("v%0d_pend", i), wb.md_pending, vt[i].pend);
    end

    // Bypass latency: empty FIFO, idle pipeline.
    drive(0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
    chk("byp_we1", wb.we, 1);
    chk("byp_addr", wb.rd_addr, 7);
    chk("byp_data", wb.rd_data, 32'hDEADBEEF);
    tick();
    chk("byp_we2", wb.we, 0);
`else
    chk("byp_we1", wb.we, 0);
    chk("byp_pend", wb.md_pending, 1);
    tick();
    chk("byp_we2", wb.we, 1);
    chk("byp_addr", wb.rd_addr, 7);
    chk("byp_data", wb.rd_data, 32'hDEADBEEF);
`endif
    tick();

    // Randomized run; last 30 cycles idle to drain.
    for (int c = 0; c < 230; c++) begin
      if (!(wb.md_valid && !wb.md_ready)) begin
        wb.md_valid = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
        wb.md_rd    = 5'($urandom_range(0, 31));
        wb.md_data  = $urandom;
      end
      wb.pipe_valid = (c < 200) && ($urandom_range(0, 9) < 4);
      wb.pipe_rd    = 5'($urandom_range(0, 31));
      wb.pipe_data  = $urandom;
      pr     = wb.pipe_valid && (wb.pipe_rd != 0);
      pa     = wb.pipe_rd;
      pdat   = wb.pipe_data;
      old_sz = q.size();
      pushed = wb.md_valid && wb.md_ready && (wb.md_rd != 0);
      if (pushed) q.push_back('{rd: wb.md_rd, d: wb.md_data});
`ifdef WB_BYPASS_EN
      exp_md_we = !pr && (old_sz > 0 || pushed);
`else
      exp_md_we = !pr && (old_sz > 0);
`endif
      tick();
      chk("rnd_we", wb.we, pr || exp_md_we);
      if (pr) begin
        chk("rnd_pipe_addr", wb.rd_addr, pa);
        chk("rnd_pipe_data", wb.rd_data, pdat);
      end else if (wb.we && q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_md_addr", wb.rd_addr, e.rd);
        chk("rnd_md_data", wb.rd_data, e.d);
      end
      chk("rnd_pend", wb.md_pending, q.size());
      chk("rnd_ready", wb.md_ready, q.size() != MD_DEPTH);
    end
    chk("rnd_drained", q.size(), 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Reset asserted mid-drain.
    drive(1, 5'd12, 32'hC, 1, 5'd14, 32'hE);
    tick();
    drive(1, 5'd13, 32'hD, 1, 5'd15, 32'hF);
    tick();
    chk("md_pend2", wb.md_pending, 2);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("md_drain_we", wb.we, 1);
    chk("md_drain_addr", wb.rd_addr, 14);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_we", wb.we, 0);
    chk("mrst_pend", wb.md_pending, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", wb.we, 0);
      chk("post_rst_rdy", wb.md_ready, 1);
      chk("post_rst_pend", wb.md_pending, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the register data width.
REQ-002 The block SHALL have parameter MD_DEPTH, default 2, giving the mul/div result buffer depth (power of 2, ≥2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pipe_valid  input  1  single-cycle pipeline result present this cycle.
REQ-006 pipe_rd  input  5  destination register of the pipeline result.
REQ-007 pipe_data  input  XLEN  pipeline result data.
REQ-008 md_valid  input  1  mul/div result offered.
REQ-009 md_ready  output  1  buffer can accept an md result; equals buffer-not-full, registered.
REQ-010 md_rd  input  5  destination register of the md result.
REQ-011 md_data  input  XLEN  md result data.
REQ-012 we  output  1  register-file write enable, registered.
REQ-013 rd_addr  output  5  register-file write address, registered.
REQ-014 rd_data  output  XLEN  register-file write data, registered.
REQ-015 md_pending  output  $clog2(MD_DEPTH)+1  current buffer occupancy, for the hazard unit.

Function
REQ-016 An md transfer SHALL occur on a rising edge where md_valid and md_ready are both 1; md_valid without md_ready SHALL leave inputs held by the source.
REQ-017 An md transfer with md_rd = 0 SHALL be accepted and discarded (never buffered, never written).
REQ-018 An md transfer with md_rd ≠ 0 SHALL be pushed into the FIFO buffer (except under REQ-030 bypass).
REQ-019 Each edge the write slot SHALL be granted in priority: (1) pipe_valid with pipe_rd ≠ 0; (2) FIFO head if FIFO non-empty; (3) none.
REQ-020 Grant (1): we←1, rd_addr←pipe_rd, rd_data←pipe_data at that edge (1-cycle latency).
REQ-021 Grant (2): FIFO head popped and driven onto we/rd_addr/rd_data at that edge.
REQ-022 Grant (3): we←0; rd_addr and rd_data SHALL hold their previous values.
REQ-023 pipe_valid with pipe_rd = 0 SHALL be treated as no pipeline request, freeing the slot for the FIFO.
REQ-024 The FIFO SHALL deliver md results strictly in acceptance order.
REQ-025 Simultaneous push and pop in one edge SHALL leave occupancy unchanged; read/write pointers SHALL wrap modulo MD_DEPTH.
REQ-026 md_ready SHALL be 0 whenever occupancy = MD_DEPTH, so overflow never occurs; a pop in the same cycle SHALL NOT make md_ready combinationally 1.
REQ-027 The pipeline path SHALL never stall; the FIFO SHALL drain only in cycles without a pipeline write.

Reset
REQ-028 While rst_n = 0: we = 0, rd_addr = 0, rd_data = 0, occupancy = 0, pointers = 0, md_ready = 1 (from the first edge after release), md_pending = 0; buffered entries SHALL be lost.
REQ-029 Reset asserted mid-drain SHALL immediately force we = 0 without waiting for a clock edge.

Configuration
REQ-030 With WB_BYPASS_EN defined: an md transfer (md_rd ≠ 0) arriving when the FIFO is empty and no pipeline request is present SHALL be written directly at that edge (1-cycle latency), bypassing the FIFO.
REQ-031 Without WB_BYPASS_EN: every buffered md result SHALL pass through the FIFO (minimum 2-cycle latency, transfer edge to we high).

Verification
REQ-032 Pipe only: pipe_valid=1, pipe_rd=1, pipe_data=A5A5A5A5 -> next cycle we=1, rd_addr=1, rd_data=A5A5A5A5; following idle cycle we=0.
REQ-033 x0 suppression: pipe_rd=0 data=FFFFFFFF and md_rd=0 data=FFFFFFFF -> we stays 0, md_pending stays 0.
REQ-034 Collision: pipe x2=11111111 and md x3=22222222 same edge, pipe idle afterwards -> x2 written first, x3 written the next cycle (no bypass).
REQ-035 Back-pressure: pipe busy 4 cycles while md offers x4, x5, x6 -> md_ready falls after 2 accepts, x6 held; on pipe idle, writes x4, x5, x6 in order.
REQ-036 Bypass: WB_BYPASS_EN defined, FIFO empty, pipe idle, md x7=DEADBEEF -> we=1, rd_addr=7 one cycle after transfer; undefined -> two cycles.
REQ-037 Reset mid-drain: two entries buffered, rst_n low -> we=0 immediately, md_pending=0; after release no stale writes appear.
